// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback path: exception
// register/codes and the layout of one pending multdiv result.
package wb_pkg;

  localparam logic [4:0]  RSTATUS_REG   = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wreg;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/md_wb_fifo.sv
// Small FIFO of pending multdiv writebacks. Entries can be invalidated in place
// by register index when a younger ALU write to the same register overtakes them.
module md_wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clock,
  input  logic               ctrl_reset_n,
  input  logic               push,
  input  logic [4:0]         push_reg,
  input  logic [31:0]        push_data,
  input  logic               pop,
  input  logic               squash,
  input  logic [4:0]         squash_reg,
  output logic [CW-1:0]      count,
  output logic [DEPTH-1:0]   entry_valid,
  output logic [DEPTH*5-1:0] entry_reg,
  output logic               head_valid,
  output logic [4:0]         head_reg,
  output logic [31:0]        head_data
);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Squash is applied before push so a freshly written tail entry is never
  // cleared; the caller already filters pushes that collide with the squash.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].wreg == squash_reg) mem_d[i].valid = 1'b0;
      end
    end
    if (pop) begin
      mem_d[head_q].valid = 1'b0;
      head_d = next_ptr(head_q);
    end
    if (push) begin
      mem_d[tail_q] = '{valid: 1'b1, wreg: push_reg, data: push_data};
      tail_d = next_ptr(tail_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    entry_valid = '0;
    entry_reg   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i]       = mem_q[i].valid;
      entry_reg[i*5 +: 5]  = mem_q[i].wreg;
    end
  end

  assign count      = count_q;
  assign head_valid = mem_q[head_q].valid;
  assign head_reg   = mem_q[head_q].wreg;
  assign head_data  = mem_q[head_q].data;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the single-cycle ALU result and buffered multdiv completions onto one
// registered register-file write port; the ALU always has priority.
module writeback_arbiter #(
  parameter logic [4:0]  RSTATUS_REG   = wb_pkg::RSTATUS_REG,
  parameter logic [31:0] MULT_EXC_CODE = wb_pkg::MULT_EXC_CODE,
  parameter logic [31:0] DIV_EXC_CODE  = wb_pkg::DIV_EXC_CODE,
  parameter int          DEPTH         = 2
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_reg,
  input  logic [31:0] alu_wb_data,
  input  logic        md_wb_valid,
  output logic        md_wb_ready,
  input  logic [4:0]  md_wb_reg,
  input  logic [31:0] md_wb_data,
  input  logic        md_wb_exc,
  input  logic        md_wb_is_div,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] pending_mask
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]      fifo_count;
  logic [DEPTH-1:0]   entry_valid;
  logic [DEPTH*5-1:0] entry_reg;
  logic               head_valid;
  logic [4:0]         head_reg;
  logic [31:0]        head_data;

  logic [4:0]  enq_reg;
  logic [31:0] enq_data;
  logic        push, pop, head_write;

  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;

  assign md_wb_ready = (fifo_count < CW'(DEPTH));

  // A faulting op reports through the status register instead of its result.
  // Writes to r0 and writes the concurrent ALU result overtakes are dropped.
  always_comb begin
    enq_reg    = md_wb_exc ? RSTATUS_REG : md_wb_reg;
    enq_data   = md_wb_exc ? (md_wb_is_div ? DIV_EXC_CODE : MULT_EXC_CODE) : md_wb_data;
    push       = md_wb_valid && md_wb_ready && (enq_reg != 5'd0) &&
                 !(alu_wb_valid && (alu_wb_reg == enq_reg));
    pop        = (fifo_count != '0) && (!head_valid || !alu_wb_valid);
    head_write = (fifo_count != '0) && head_valid && !alu_wb_valid;
  end

  md_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .push         (push),
    .push_reg     (enq_reg),
    .push_data    (enq_data),
    .pop          (pop),
    .squash       (alu_wb_valid),
    .squash_reg   (alu_wb_reg),
    .count        (fifo_count),
    .entry_valid  (entry_valid),
    .entry_reg    (entry_reg),
    .head_valid   (head_valid),
    .head_reg     (head_reg),
    .head_data    (head_data)
  );

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (alu_wb_valid) begin
      if (alu_wb_reg != 5'd0) begin
        we_d    = 1'b1;
        wreg_d  = alu_wb_reg;
        wdata_d = alu_wb_data;
      end
    end else if (head_write) begin
      we_d    = 1'b1;
      wreg_d  = head_reg;
      wdata_d = head_data;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_mask[entry_reg[i*5 +: 5]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b1;
  logic        alu_wb_valid = 1'b0;
  logic [4:0]  alu_wb_reg = '0;
  logic [31:0] alu_wb_data = '0;
  logic        md_wb_valid = 1'b0;
  logic        md_wb_ready;
  logic [4:0]  md_wb_reg = '0;
  logic [31:0] md_wb_data = '0;
  logic        md_wb_exc = 1'b0;
  logic        md_wb_is_div = 1'b0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] pending_mask;

  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .alu_wb_valid     (alu_wb_valid),
    .alu_wb_reg       (alu_wb_reg),
    .alu_wb_data      (alu_wb_data),
    .md_wb_valid      (md_wb_valid),
    .md_wb_ready      (md_wb_ready),
    .md_wb_reg        (md_wb_reg),
    .md_wb_data       (md_wb_data),
    .md_wb_exc        (md_wb_exc),
    .md_wb_is_div     (md_wb_is_div),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .pending_mask     (pending_mask)
  );

  always #5 clock = ~clock;

  // Reference model: an ordered list of pending results plus the expected
  // write port, advanced once per rising edge from the inputs seen there.
  typedef struct packed {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
  } mentry_t;

  mentry_t     mq[$];
  logic        exp_we = 1'b0;
  logic [4:0]  exp_reg = '0;
  logic [31:0] exp_data = '0;
  logic        md_accepted = 1'b0;
  logic        can_accept;
  logic [4:0]  tr;
  logic [31:0] td;

  always @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      mq.delete();
      exp_we = 1'b0;
      exp_reg = '0;
      exp_data = '0;
      md_accepted = 1'b0;
    end else begin
      can_accept = (mq.size() < DEPTH);
      exp_we = 1'b0;
      if (alu_wb_valid && alu_wb_reg != 5'd0) begin
        exp_we = 1'b1;
        exp_reg = alu_wb_reg;
        exp_data = alu_wb_data;
      end
      if (mq.size() > 0) begin
        if (!mq[0].v) begin
          void'(mq.pop_front());
        end else if (!alu_wb_valid) begin
          exp_we = 1'b1;
          exp_reg = mq[0].r;
          exp_data = mq[0].d;
          void'(mq.pop_front());
        end
      end
      if (alu_wb_valid) begin
        foreach (mq[i]) if (mq[i].r == alu_wb_reg) mq[i].v = 1'b0;
      end
      md_accepted = md_wb_valid && can_accept;
      if (md_accepted) begin
        tr = md_wb_exc ? 5'd30 : md_wb_reg;
        td = md_wb_exc ? (md_wb_is_div ? 32'd5 : 32'd4) : md_wb_data;
        if (tr != 5'd0 && !(alu_wb_valid && alu_wb_reg == tr))
          mq.push_back('{v: 1'b1, r: tr, d: td});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  logic [31:0] cmp_mask;
  always @(negedge clock) begin
    cmp_mask = '0;
    foreach (mq[i]) if (mq[i].v) cmp_mask[mq[i].r] = 1'b1;
    cmp_mask[0] = 1'b0;
    checkOutput("model_we", {31'd0, ctrl_writeEnable}, {31'd0, exp_we});
    checkOutput("model_reg", {27'd0, ctrl_writeReg}, {27'd0, exp_reg});
    checkOutput("model_data", data_writeReg, exp_data);
    checkOutput("model_ready", {31'd0, md_wb_ready}, {31'd0, (mq.size() < DEPTH)});
    checkOutput("model_mask", pending_mask, cmp_mask);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mr, input logic [31:0] md,
                               input logic mexc, input logic mdiv);
    alu_wb_valid = av; alu_wb_reg = ar; alu_wb_data = ad;
    md_wb_valid = mv; md_wb_reg = mr; md_wb_data = md;
    md_wb_exc = mexc; md_wb_is_div = mdiv;
    step();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [4:0] pickReg();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? 5'd30 : 5'(r);
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 ctrl_reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
    checkOutput("reset_reg", {27'd0, ctrl_writeReg}, 32'd0);
    checkOutput("reset_data", data_writeReg, 32'd0);
    checkOutput("reset_mask", pending_mask, 32'd0);
    checkOutput("reset_ready", {31'd0, md_wb_ready}, 32'd1);
    ctrl_reset_n = 1'b1;
    idle();

    // ALU one-cycle latency
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("alu_we", {31'd0, ctrl_writeEnable}, 32'd1);
    checkOutput("alu_reg", {27'd0, ctrl_writeReg}, 32'd5);
    checkOutput("alu_data", data_writeReg, 32'h0000_1234);
    idle();
    checkOutput("idle_we", {31'd0, ctrl_writeEnable}, 32'd0);
    checkOutput("idle_hold_data", data_writeReg, 32'h0000_1234);

    // Multdiv waits behind two busy ALU cycles
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput("md_pending7", pending_mask, 32'h0000_0080);
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("md_alu1_reg", {27'd0, ctrl_writeReg}, 32'd1);
    checkOutput("md_pending7_b", pending_mask, 32'h0000_0080);
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("md_pending7_c", pending_mask, 32'h0000_0080);
    idle();
    checkOutput("md_r7_we", {31'd0, ctrl_writeEnable}, 32'd1);
    checkOutput("md_r7_reg", {27'd0, ctrl_writeReg}, 32'd7);
    checkOutput("md_r7_data", data_writeReg, 32'hDEADBEEF);
    checkOutput("md_r7_mask", pending_mask, 32'd0);

    // Buffer fills, third transfer held, drains in order
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'd8, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'd9, 1'b0, 1'b0);
    checkOutput("full_ready", {31'd0, md_wb_ready}, 32'd0);
    checkOutput("full_mask", pending_mask, 32'h0000_0300);
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'd10, 1'b0, 1'b0);
    checkOutput("held_ready", {31'd0, md_wb_ready}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'd10, 1'b0, 1'b0);
    checkOutput("drain_r8_reg", {27'd0, ctrl_writeReg}, 32'd8);
    checkOutput("drain_r8_data", data_writeReg, 32'd8);
    checkOutput("drain_r8_mask", pending_mask, 32'h0000_0200);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'd10, 1'b0, 1'b0);
    checkOutput("drain_r9_reg", {27'd0, ctrl_writeReg}, 32'd9);
    checkOutput("drain_r10_mask", pending_mask, 32'h0000_0400);
    idle();
    checkOutput("drain_r10_reg", {27'd0, ctrl_writeReg}, 32'd10);
    checkOutput("drain_r10_data", data_writeReg, 32'd10);

    // Younger ALU write squashes buffered r3
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h333, 1'b0, 1'b0);
    checkOutput("sq_mask_before", pending_mask, 32'h0000_0008);
    applyStimulus(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("sq_alu_reg", {27'd0, ctrl_writeReg}, 32'd3);
    checkOutput("sq_alu_data", data_writeReg, 32'h1);
    checkOutput("sq_mask_after", pending_mask, 32'd0);
    idle();
    checkOutput("sq_pop_we", {31'd0, ctrl_writeEnable}, 32'd0);
    checkOutput("sq_pop_data", data_writeReg, 32'h1);

    // Exceptions and r0 writes
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hABCD, 1'b1, 1'b1);
    idle();
    checkOutput("exc_div_reg", {27'd0, ctrl_writeReg}, 32'd30);
    checkOutput("exc_div_data", data_writeReg, 32'd5);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hABCD, 1'b1, 1'b0);
    idle();
    checkOutput("exc_mult_we", {31'd0, ctrl_writeEnable}, 32'd1);
    checkOutput("exc_mult_data", data_writeReg, 32'd4);
    applyStimulus(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("alu_r0_we", {31'd0, ctrl_writeEnable}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hAA, 1'b0, 1'b0);
    checkOutput("md_r0_mask", pending_mask, 32'd0);
    idle();
    checkOutput("md_r0_we", {31'd0, ctrl_writeEnable}, 32'd0);

    // Reset with two entries buffered
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'd20, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd21, 32'd21, 1'b0, 1'b0);
    checkOutput("rst_full_ready", {31'd0, md_wb_ready}, 32'd0);
    checkOutput("rst_full_mask", pending_mask, 32'h0030_0000);
    alu_wb_valid = 1'b0; md_wb_valid = 1'b0;
    ctrl_reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_we", {31'd0, ctrl_writeEnable}, 32'd0);
    checkOutput("rst_mid_reg", {27'd0, ctrl_writeReg}, 32'd0);
    checkOutput("rst_mid_data", data_writeReg, 32'd0);
    checkOutput("rst_mid_mask", pending_mask, 32'd0);
    checkOutput("rst_mid_ready", {31'd0, md_wb_ready}, 32'd1);
    step();
    ctrl_reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      checkOutput("rst_after_we", {31'd0, ctrl_writeEnable}, 32'd0);
    end

    // Random traffic; the producer holds an offered transfer until accepted
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        alu_wb_valid = 1'b0;
        md_wb_valid = 1'b0;
        ctrl_reset_n = 1'b0;
        step();
        ctrl_reset_n = 1'b1;
        step();
      end else begin
        if (!(md_wb_valid && !md_accepted)) begin
          md_wb_valid = ($urandom_range(0, 1) == 1);
          md_wb_reg = pickReg();
          md_wb_data = $urandom;
          md_wb_exc = ($urandom_range(0, 7) == 0);
          md_wb_is_div = 1'($urandom_range(0, 1));
        end
        alu_wb_valid = ($urandom_range(0, 2) == 0);
        alu_wb_reg = pickReg();
        alu_wb_data = $urandom;
        step();
      end
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
